// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle MDU hold and taken-branch flush.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int RS_WIDTH = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RS_WIDTH-1:0] rs1_id,
  input  logic [RS_WIDTH-1:0] rs2_id,
  input  logic                rs1_used_id,
  input  logic                rs2_used_id,
  input  logic [RS_WIDTH-1:0] rd_ex,
  input  logic                memread_ex,
  input  logic                mdu_start_ex,
  input  logic                mdu_done,
  input  logic                branch_taken_ex,
  output logic                pcwrite,
  output logic                ifidwrite,
  output logic                clearcontrol,
  output logic                ifid_flush,
  output logic                exhold,
  output logic [31:0]         stall_cycles
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MDU_WAIT   = 2'd2
  } state_e;

  localparam logic [3:0] LOAD_INIT  = 4'(LOAD_LAT - 1);
  localparam logic       LOAD_MULTI = (LOAD_LAT > 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use_s;

  assign load_use_s = memread_ex && (rd_ex != '0) &&
                      (((rd_ex == rs1_id) && rs1_used_id) ||
                       ((rd_ex == rs2_id) && rs2_used_id));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (branch_taken_ex) begin
          state_d = IDLE;
        end else if (mdu_start_ex) begin
          state_d = MDU_WAIT;
        end else if (load_use_s && LOAD_MULTI) begin
          state_d = LOAD_STALL;
          cnt_d   = LOAD_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_STALL: begin
        // The bubble issued while cnt_q==1 is the last one.
        if (branch_taken_ex || (cnt_q <= 4'd1)) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done) begin
          state_d = IDLE;
        end else begin
          state_d = MDU_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    pcwrite      = 1'b1;
    ifidwrite    = 1'b1;
    clearcontrol = 1'b0;
    ifid_flush   = 1'b0;
    exhold       = 1'b0;
    if (rst) begin
      pcwrite = 1'b1;
    end else begin
      case (state_q)
        IDLE, LOAD_STALL: begin
          if (branch_taken_ex) begin
            ifid_flush   = 1'b1;
            clearcontrol = 1'b1;
          end else if ((state_q == LOAD_STALL) ||
                       (load_use_s && !mdu_start_ex)) begin
            pcwrite      = 1'b0;
            ifidwrite    = 1'b0;
            clearcontrol = 1'b1;
          end else begin
            clearcontrol = 1'b0;
          end
        end
        MDU_WAIT: begin
          if (!mdu_done) begin
            pcwrite   = 1'b0;
            ifidwrite = 1'b0;
            exhold    = 1'b1;
          end else begin
            exhold = 1'b0;
          end
        end
        default: begin
          pcwrite = 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else if (!pcwrite) begin
      stall_q <= stall_q + 32'd1;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter RS_WIDTH, 5, register-specifier width.
REQ-002 SHALL have parameter LOAD_LAT, 1, load-use bubble count (legal 1..15).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports rs1_id, rs2_id  in  RS_WIDTH  ID-stage source registers.
REQ-006 SHALL have ports rs1_used_id, rs2_used_id  in  1  source actually read by ID instruction.
REQ-007 SHALL have port rd_ex  in  RS_WIDTH  EX-stage destination register.
REQ-008 SHALL have port memread_ex  in  1  EX-stage instruction is a load.
REQ-009 SHALL have port mdu_start_ex  in  1  single-cycle pulse: multi-cycle mul/div entered EX.
REQ-010 SHALL have port mdu_done  in  1  mul/div result valid this cycle.
REQ-011 SHALL have port branch_taken_ex  in  1  redirect resolved in EX.
REQ-012 SHALL have ports pcwrite, ifidwrite  out  1  PC / IF-ID register write enables.
REQ-013 SHALL have port clearcontrol  out  1  zero ID-EX control (bubble insert).
REQ-014 SHALL have port ifid_flush  out  1  invalidate IF-ID contents.
REQ-015 SHALL have port exhold  out  1  hold ID-EX and EX stage contents.
REQ-016 SHALL have port stall_cycles  out  32  cumulative stall-cycle count.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD_STALL, MDU_WAIT.
REQ-018 SHALL detect load-use as memread_ex & rd_ex!=0 & ((rd_ex==rs1_id & rs1_used_id) | (rd_ex==rs2_id & rs2_used_id)), combinationally.
REQ-019 In IDLE with load-use: pcwrite=0, ifidwrite=0, clearcontrol=1 same cycle; if LOAD_LAT>1, go LOAD_STALL with counter=LOAD_LAT-1, else stay IDLE.
REQ-020 In LOAD_STALL: pcwrite=0, ifidwrite=0, clearcontrol=1 every cycle; counter decrements; exit to IDLE in the cycle counter reaches 1 (total bubbles = LOAD_LAT).
REQ-021 In IDLE with mdu_start_ex: go MDU_WAIT next cycle; no stall in start cycle.
REQ-022 In MDU_WAIT: pcwrite=0, ifidwrite=0, exhold=1, clearcontrol=0 until mdu_done; in the mdu_done cycle all stall outputs release and FSM returns IDLE.
REQ-023 mdu_done in IDLE or LOAD_STALL SHALL be ignored.
REQ-024 branch_taken_ex in IDLE or LOAD_STALL: ifid_flush=1, clearcontrol=1, pcwrite=1, ifidwrite=1 same cycle; overrides load-use; LOAD_STALL aborts to IDLE.
REQ-025 branch_taken_ex in MDU_WAIT SHALL be ignored.
REQ-026 Priority in IDLE: branch_taken_ex > mdu_start_ex > load-use.
REQ-027 Idle outputs: pcwrite=1, ifidwrite=1, clearcontrol=0, ifid_flush=0, exhold=0.
REQ-028 A stall cycle SHALL be any cycle with pcwrite=0.

Reset
REQ-029 rst SHALL force IDLE, counter=0, stall_cycles=0 asynchronously, including mid-LOAD_STALL or mid-MDU_WAIT.
REQ-030 During reset outputs SHALL equal REQ-027 values.

Configuration
REQ-031 With HAZARD_PERF_EN defined, stall_cycles SHALL increment by 1 per stall cycle, wrapping 0xFFFFFFFF->0.
REQ-032 Without HAZARD_PERF_EN, stall_cycles SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-033 LOAD_LAT=1, memread_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 -> one cycle pcwrite=0, clearcontrol=1; next cycle idle outputs.
REQ-034 LOAD_LAT=3, same hazard -> exactly 3 consecutive bubble cycles; rd_ex=0 case -> no stall.
REQ-035 mdu_start_ex pulse, mdu_done 4 cycles later -> exhold=1 for 3 cycles, released in the done cycle.
REQ-036 LOAD_LAT=3, branch_taken_ex in 2nd bubble -> ifid_flush=1, pcwrite=1 that cycle, IDLE next.
REQ-037 rst asserted mid-MDU_WAIT -> idle outputs immediately, stall_cycles=0; with HAZARD_PERF_EN, REQ-034 run -> stall_cycles=3.
